// File: rtl/ldm_stm_seq_pkg.sv
// Shared types for the LDM/STM block-transfer sequencer: modes, FSM states, popcount.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package ldm_stm_seq_pkg;

  // Addressing modes in {P,U} bit order.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_WBACK = 2'd2
  } state_t;

  // Number of registers named in a 16-bit register list.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Bundle of control, register-file and memory-beat signals of the sequencer.
// Latency: none (wiring only).
// Backpressure: i_mem_ready stalls the sequencer's memory beats; en freezes it entirely.
interface ldm_stm_seq_if;
  logic        en;
  logic        i_start;
  logic        i_load;
  logic [1:0]  i_mode;
  logic        i_wback;
  logic [3:0]  i_rn_code;
  logic [31:0] i_base;
  logic [15:0] i_reg_list;
  logic        o_busy;
  logic [3:0]  o_re_code;
  logic [31:0] i_re_reg;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;
  logic        o_rd_en;
  logic [3:0]  o_rd_code;
  logic [31:0] o_rd_reg;
  logic        o_done;

  // Sequencer side: it masters the memory beats and the register-file ports.
  modport master (
    input  en, i_start, i_load, i_mode, i_wback, i_rn_code, i_base, i_reg_list,
           i_re_reg, i_mem_ready, i_mem_rdata,
    output o_busy, o_re_code, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
           o_rd_en, o_rd_code, o_rd_reg, o_done
  );

  // Environment side: core control, register file and memory.
  modport slave (
    output en, i_start, i_load, i_mode, i_wback, i_rn_code, i_base, i_reg_list,
           i_re_reg, i_mem_ready, i_mem_rdata,
    input  o_busy, o_re_code, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
           o_rd_en, o_rd_code, o_rd_reg, o_done
  );
endinterface

// File: rtl/ldm_prio_enc.sv
// Lowest-set-bit priority encoder over a 16-bit register list.
// Latency: combinational.
// Backpressure: not applicable.
module ldm_prio_enc (
  input  logic [15:0] req,
  output logic [3:0]  idx,
  output logic        vld
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

  assign vld = |req;

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: one memory beat per listed register, ascending order.
// Latency: first beat the cycle after start; load writes appear the cycle after each beat retires.
// Backpressure: beats wait on i_mem_ready; en=0 freezes all state. Optional base writeback: LDM_STM_WBACK_EN.
module ldm_stm_seq
  import ldm_stm_seq_pkg::*;
(
  input logic            clk,
  input logic            rst,
  ldm_stm_seq_if.master  bus
);

  state_t      state;
  logic [15:0] list;
  logic        load_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rd_en_q;
  logic [3:0]  rd_code_q;
  logic [31:0] rd_reg_q;
  logic        done_q;
`ifdef LDM_STM_WBACK_EN
  logic        wb_do;
  logic [3:0]  rn_q;
  logic [31:0] wb_val;
`endif

  logic [3:0]  cur_idx;
  logic        cur_vld;
  logic        mem_req;
  logic        last;
  logic [4:0]  n_start;
  logic [31:0] span;
  logic [31:0] start_addr;

  ldm_prio_enc u_prio (
    .req (list),
    .idx (cur_idx),
    .vld (cur_vld)
  );

  assign mem_req = (state == ST_XFER) && cur_vld;
  // Only one register left means this beat is the final one.
  assign last    = (list & (list - 16'd1)) == 16'd0;
  assign n_start = popcount16(bus.i_reg_list);
  assign span    = {25'd0, n_start, 2'b00};

  // First beat address from the P/U mode bits.
  always_comb begin
    start_addr = bus.i_base;
    case (mode_t'(bus.i_mode))
      MODE_IA: start_addr = bus.i_base;
      MODE_IB: start_addr = bus.i_base + 32'd4;
      MODE_DA: start_addr = bus.i_base - span + 32'd4;
      MODE_DB: start_addr = bus.i_base - span;
      default: start_addr = bus.i_base;
    endcase
  end

  // Sequencer FSM with registered address, write-back port and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      list      <= '0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_code_q <= '0;
      rd_reg_q  <= '0;
      done_q    <= 1'b0;
`ifdef LDM_STM_WBACK_EN
      wb_do     <= 1'b0;
      rn_q      <= '0;
      wb_val    <= '0;
`endif
    end else if (bus.en) begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            list   <= bus.i_reg_list;
            load_q <= bus.i_load;
`ifdef LDM_STM_WBACK_EN
            rn_q   <= bus.i_rn_code;
            // A loaded base wins over the writeback value.
            wb_do  <= bus.i_wback && !(bus.i_load && bus.i_reg_list[bus.i_rn_code]);
            wb_val <= bus.i_mode[0] ? (bus.i_base + span) : (bus.i_base - span);
`endif
            if (n_start == 5'd0) begin
              // Empty list: nothing to move, address left untouched.
              done_q <= 1'b1;
            end else begin
              addr_q <= start_addr;
              state  <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          wdata_q <= bus.i_re_reg;
          if (bus.i_mem_ready && cur_vld) begin
            list <= list & ~(16'd1 << cur_idx);
            if (load_q) begin
              rd_en_q   <= 1'b1;
              rd_code_q <= cur_idx;
              rd_reg_q  <= bus.i_mem_rdata;
            end
            if (last) begin
`ifdef LDM_STM_WBACK_EN
              if (wb_do) begin
                state <= ST_WBACK;
              end else begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end
`else
              state  <= ST_IDLE;
              done_q <= 1'b1;
`endif
            end else begin
              // Final beat leaves the address on the last word moved.
              addr_q <= addr_q + 32'd4;
            end
          end
        end
`ifdef LDM_STM_WBACK_EN
        ST_WBACK: begin
          rd_en_q   <= 1'b1;
          rd_code_q <= rn_q;
          rd_reg_q  <= wb_val;
          done_q    <= 1'b1;
          state     <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_re_code   = cur_idx;
  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_req && !load_q;
  assign bus.o_mem_addr  = addr_q;
  // Store data flows straight from the register file during a beat, then holds.
  assign bus.o_mem_wdata = mem_req ? bus.i_re_reg : wdata_q;
  assign bus.o_rd_en     = rd_en_q;
  assign bus.o_rd_code   = rd_code_q;
  assign bus.o_rd_reg    = rd_reg_q;
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed transfers, scoreboard-checked beats and writes.
// Latency: n/a.
// Backpressure: exercises i_mem_ready stalls and en freezes.
module tb_ldm_stm_seq;
  import ldm_stm_seq_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ldm_stm_seq_if bus();

  ldm_stm_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file and memory models: data is a fixed function of code / address.
  assign bus.i_re_reg    = 32'hCAFE_0000 | {28'd0, bus.o_re_code};
  assign bus.i_mem_rdata = bus.o_mem_addr ^ 32'hDEAD_0000;

  beat_t beat_q[$];
  wr_t   wr_q[$];
  beat_t eb;
  wr_t   ew;
  int    total = 0;
  int    bad = 0;
  int    done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void push_beat(input logic [31:0] a, input logic we, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.we = we; b.wdata = d;
    beat_q.push_back(b);
  endfunction

  function automatic void push_wr(input logic [3:0] c, input logic [31:0] d);
    wr_t w;
    w.code = c; w.data = d;
    wr_q.push_back(w);
  endfunction

  // Monitor: retire beats, register writes and done pulses against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.en && bus.o_mem_req && bus.i_mem_ready) begin
        if (beat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected: got addr %h, no beat expected", bus.o_mem_addr);
        end else begin
          eb = beat_q.pop_front();
          check("beat_addr", bus.o_mem_addr, eb.addr);
          check("beat_we", {31'd0, bus.o_mem_we}, {31'd0, eb.we});
          if (eb.we) check("beat_wdata", bus.o_mem_wdata, eb.wdata);
        end
      end
      if (bus.o_rd_en) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got code %0d data %h, no write expected",
                   bus.o_rd_code, bus.o_rd_reg);
        end else begin
          ew = wr_q.pop_front();
          check("rd_code", {28'd0, bus.o_rd_code}, {28'd0, ew.code});
          check("rd_reg", bus.o_rd_reg, ew.data);
        end
      end
      if (bus.o_done) done_seen++;
    end
  end

  task automatic start_xfer(input logic ld, input logic [1:0] md, input logic wb,
                            input logic [3:0] rn, input logic [31:0] base, input logic [15:0] lst);
    @(posedge clk); #1;
    bus.i_load = ld; bus.i_mode = md; bus.i_wback = wb;
    bus.i_rn_code = rn; bus.i_base = base; bus.i_reg_list = lst;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int c = 0; c < 200 && done_seen < target; c++) @(posedge clk);
    #1;
    total++;
    if (done_seen < target) begin
      bad++;
      $display("FAIL %s: got done count %0d want %0d (timeout)", name, done_seen, target);
    end
  endtask

  initial begin
    bus.en = 1'b1; bus.i_start = 1'b0; bus.i_load = 1'b0; bus.i_mode = 2'b00;
    bus.i_wback = 1'b0; bus.i_rn_code = '0; bus.i_base = '0; bus.i_reg_list = '0;
    bus.i_mem_ready = 1'b0;

    // Reset state
    #12;
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_req", {31'd0, bus.o_mem_req}, 32'd0);
    check("rst_addr", bus.o_mem_addr, 32'd0);
    check("rst_wdata", bus.o_mem_wdata, 32'd0);
    check("rst_rd_en", {31'd0, bus.o_rd_en}, 32'd0);
    check("rst_done", {31'd0, bus.o_done}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // LDM IA, four registers, memory always ready
    bus.i_mem_ready = 1'b1;
    push_beat(32'h1000, 1'b0, 32'h0); push_beat(32'h1004, 1'b0, 32'h0);
    push_beat(32'h1008, 1'b0, 32'h0); push_beat(32'h100C, 1'b0, 32'h0);
    push_wr(4'd0, 32'hDEAD1000); push_wr(4'd1, 32'hDEAD1004);
    push_wr(4'd2, 32'hDEAD1008); push_wr(4'd3, 32'hDEAD100C);
    start_xfer(1'b1, MODE_IA, 1'b0, 4'd0, 32'h1000, 16'h000F);
    wait_done(1, "ldm_ia_done");

    // STM DB with writeback of R13
    push_beat(32'h1FF8, 1'b1, 32'hCAFE0004); push_beat(32'h1FFC, 1'b1, 32'hCAFE000E);
`ifdef LDM_STM_WBACK_EN
    push_wr(4'd13, 32'h1FF8);
`endif
    start_xfer(1'b0, MODE_DB, 1'b1, 4'd13, 32'h2000, 16'h4010);
    wait_done(2, "stm_db_done");

    // LDM IB with base in the list: load wins, no writeback
    push_beat(32'h3004, 1'b0, 32'h0);
    push_wr(4'd2, 32'hDEAD3004);
    start_xfer(1'b1, MODE_IB, 1'b1, 4'd2, 32'h3000, 16'h0004);
    wait_done(3, "ldm_ib_done");

    // STM IA with memory stalls and an en freeze
    bus.i_mem_ready = 1'b0;
    push_beat(32'h4000, 1'b1, 32'hCAFE0000); push_beat(32'h4004, 1'b1, 32'hCAFE0001);
    start_xfer(1'b0, MODE_IA, 1'b0, 4'd0, 32'h4000, 16'h0003);
    repeat (3) begin
      @(negedge clk);
      check("stall_req", {31'd0, bus.o_mem_req}, 32'd1);
      check("stall_addr", bus.o_mem_addr, 32'h4000);
      check("stall_wdata", bus.o_mem_wdata, 32'hCAFE0000);
    end
    @(posedge clk); #1;
    bus.en = 1'b0; bus.i_mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("freeze_addr", bus.o_mem_addr, 32'h4000);
      check("freeze_busy", {31'd0, bus.o_busy}, 32'd1);
    end
    @(posedge clk); #1 bus.en = 1'b1;
    wait_done(4, "stm_stall_done");
    @(negedge clk);
    check("idle_req", {31'd0, bus.o_mem_req}, 32'd0);
    check("hold_addr", bus.o_mem_addr, 32'h4004);
    check("hold_wdata", bus.o_mem_wdata, 32'hCAFE0001);

    // Empty list: done the cycle after start, no beats, address untouched
    start_xfer(1'b1, MODE_IA, 1'b1, 4'd0, 32'h7000, 16'h0000);
    @(negedge clk);
    check("empty_done", {31'd0, bus.o_done}, 32'd1);
    check("empty_req", {31'd0, bus.o_mem_req}, 32'd0);
    check("empty_busy", {31'd0, bus.o_busy}, 32'd0);
    check("empty_addr", bus.o_mem_addr, 32'h4004);
    @(negedge clk);
    check("empty_done_pulse", {31'd0, bus.o_done}, 32'd0);
    wait_done(5, "empty_done_cnt");

    // Start while busy is ignored
    bus.i_mem_ready = 1'b0;
    push_beat(32'h5000, 1'b0, 32'h0); push_beat(32'h5004, 1'b0, 32'h0);
    push_wr(4'd0, 32'hDEAD5000); push_wr(4'd1, 32'hDEAD5004);
    start_xfer(1'b1, MODE_IA, 1'b0, 4'd0, 32'h5000, 16'h0003);
    bus.i_load = 1'b0; bus.i_reg_list = 16'h00F0; bus.i_base = 32'h9000; bus.i_start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("busy_addr", bus.o_mem_addr, 32'h5000);
    bus.i_mem_ready = 1'b1;
    wait_done(6, "busy_start_done");
    repeat (3) @(negedge clk);
    check("busy_idle", {31'd0, bus.o_busy}, 32'd0);

    // Reset after the second LDM beat: pending write dropped, nothing further
    push_beat(32'h6000, 1'b0, 32'h0); push_beat(32'h6004, 1'b0, 32'h0);
    push_wr(4'd0, 32'hDEAD6000);
    start_xfer(1'b1, MODE_IA, 1'b0, 4'd0, 32'h6000, 16'h00FF);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("mid_rst_req", {31'd0, bus.o_mem_req}, 32'd0);
    check("mid_rst_addr", bus.o_mem_addr, 32'd0);
    check("mid_rst_wdata", bus.o_mem_wdata, 32'd0);
    check("mid_rst_re_code", {28'd0, bus.o_re_code}, 32'd0);
    check("mid_rst_rd_en", {31'd0, bus.o_rd_en}, 32'd0);
    check("mid_rst_rd_reg", bus.o_rd_reg, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_busy", {31'd0, bus.o_busy}, 32'd0);

    // Scoreboard drained and done count exact
    check("beats_left", beat_q.size(), 32'd0);
    check("writes_left", wr_q.size(), 32'd0);
    check("done_total", done_seen, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ldm_stm_seq.md
LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 The block SHALL have these ports; clock and reset come first:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  pipeline advance; state holds when low
- i_start  in  1  begin block transfer; sampled only in IDLE
- i_load  in  1  1=LDM, 0=STM
- i_mode  in  2  00=DA, 01=IA, 10=DB, 11=IB (P,U bits)
- i_wback  in  1  base writeback requested (W bit)
- i_rn_code  in  4  base register number
- i_base  in  32  base register value
- i_reg_list  in  16  register list, bit n = Rn
- o_busy  out  1  sequencer not IDLE
- o_re_code  out  4  register-file read code for STM store data
- i_re_reg  in  32  register-file read data for o_re_code
- o_mem_req  out  1  memory beat valid
- o_mem_we  out  1  1=store beat
- o_mem_addr  out  32  word address of beat
- o_mem_wdata  out  32  store data (= i_re_reg)
- i_mem_ready  in  1  beat accepted this cycle
- i_mem_rdata  in  32  load data, valid with i_mem_ready
- o_rd_en  out  1  register-file write strobe (WB port)
- o_rd_code  out  4  destination register
- o_rd_reg  out  32  write data
- o_done  out  1  one-cycle completion pulse

Function
REQ-002 States SHALL be IDLE, XFER and WBACK; when en=0, state, counters, address and outputs SHALL hold.
REQ-003 In IDLE with en=1 and i_start=1, the block SHALL latch list, mode, load, wback, rn and base, compute N=popcount(list), and enter XFER next cycle (1-cycle latency to the first beat).
REQ-004 Start address SHALL be: IA=base; IB=base+4; DA=base-4N+4; DB=base-4N (32-bit modulo wrap). Each retired beat SHALL add 4.
REQ-005 Registers SHALL transfer in ascending order; the current register is the lowest set bit of the remaining list, which is cleared when the beat retires (en & o_mem_req & i_mem_ready).
REQ-006 In XFER: o_mem_req=1; o_mem_we=!load; o_re_code=current register; o_mem_wdata=i_re_reg.
REQ-007 LDM retire SHALL produce o_rd_en=1, o_rd_code=register and o_rd_reg=i_mem_rdata, registered, valid the cycle after retire for exactly one cycle; a loaded R15 passes through unchanged.
REQ-008 After the last beat retires: go to WBACK if wback=1 and not (load and Rn in list), otherwise return to IDLE with o_done=1.
REQ-009 WBACK (1 cycle) SHALL drive o_rd_en=1, o_rd_code=rn and o_rd_reg=base+4N (U=1) or base-4N (U=0), then return to IDLE with o_done=1.
REQ-010 STM with Rn in list SHALL store the original base value (writeback occurs after all beats).
REQ-011 An empty list SHALL perform no beats and no writeback, and SHALL pulse o_done one cycle after start.
REQ-012 i_start while o_busy=1 SHALL be ignored.
REQ-013 When o_mem_req=0, o_mem_addr and o_mem_wdata SHALL hold their last values.

Reset
REQ-014 rst=1 SHALL asynchronously force IDLE and zero all outputs, list, counters and address, including mid-transfer; any pending o_rd_en is dropped.

Configuration
REQ-015 With LDM_STM_WBACK_EN defined, REQ-008/009 SHALL apply; without it, i_wback SHALL be ignored, WBACK SHALL not exist, and o_rd_en SHALL only signal load data.

Structure
REQ-016 A shared package SHALL hold the mode encodings (DA/IA/DB/IB), the state enumeration, and the 16-bit popcount function.
REQ-017 Lowest-set-bit selection SHALL be a sub-module, ldm_prio_enc (16-bit in, 4-bit index out, valid flag).

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- LDM IA, base=0x1000, list=0x000F, ready always -> addrs 0x1000..0x100C, rd_code 0..3 with rdata, done after 4 beats.
- STM DB wback, rn=13, base=0x2000, list=0x4010 -> addrs 0x1FF8(R4), 0x1FFC(R14), WBACK rd_code=13 rd_reg=0x1FF8.
- LDM IB wback, rn=2, list=0x0004 -> addr base+4, R2 loaded, no WBACK, done.
- STM IA list=0x0003, i_mem_ready=0 for 3 cycles then 1, plus en=0 for 2 cycles -> addr/wdata stable, no beat skipped.
- Empty list -> no o_mem_req, done 1 cycle after start; i_start during busy ignored.
- rst mid-LDM after beat 2 -> IDLE, all outputs 0, no further rd_en.
